// File: rtl/uart_cmd_stream_tx.sv
// UART command-stream transmitter: serialises up to MAX_BYTES bytes of a command
// word, most-significant selected byte first, as back-to-back configurable frames.
module uart_cmd_stream_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BYTES      = 4,
  parameter int BYTE_CNT_WIDTH = 3,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0] CMD_DATA,
  input  logic [BYTE_CNT_WIDTH-1:0]       CMD_LEN,
  input  logic                            CMD_VLD,
  output logic                            CMD_RDY,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            STOP2,
  input  logic [PRESCALE_WIDTH-1:0]       BIT_PERIOD,
  output logic                            TX_OUT,
  output logic                            BUSY,
  output logic                            BYTE_DONE,
  output logic                            CMD_DONE
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BYTE_CNT_WIDTH-1:0] MAX_LEN = BYTE_CNT_WIDTH'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                          state, state_nxt;
  logic                            tx_q, tx_nxt;
  logic                            byte_done_q, byte_done_nxt;
  logic                            cmd_done_q, cmd_done_nxt;
  logic                            busy_q, busy_nxt;
  logic [PRESCALE_WIDTH-1:0]       cnt, pm1_q;
  logic [BIT_W-1:0]                bit_idx;
  logic [BYTE_CNT_WIDTH-1:0]       byte_cnt;
  logic [MAX_BYTES*DATA_WIDTH-1:0] cmd_q;
  logic [DATA_WIDTH-1:0]           sh_q, cur_byte;
  logic                            par_en_q, par_typ_q, stop2_q, par_q;
  logic                            accept, bit_end, load_byte;

  function automatic logic [BYTE_CNT_WIDTH-1:0] clamp_len(input logic [BYTE_CNT_WIDTH-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic logic [PRESCALE_WIDTH-1:0] period_m1(input logic [PRESCALE_WIDTH-1:0] bp);
    return (bp == '0) ? '0 : bp - PRESCALE_WIDTH'(1);
  endfunction

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

  assign accept    = (state == IDLE) && CMD_VLD;
  assign bit_end   = (cnt == pm1_q);
  assign load_byte = (state == START) && bit_end;

  // byte_cnt counts down, so the byte on the wire is always index byte_cnt-1
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (byte_cnt == BYTE_CNT_WIDTH'(i + 1))
        cur_byte = cmd_q[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_nxt     = state;
    tx_nxt        = tx_q;
    byte_done_nxt = 1'b0;
    cmd_done_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (CMD_VLD) begin
          if (clamp_len(CMD_LEN) == '0) begin
            cmd_done_nxt = 1'b1;
            busy_nxt     = 1'b1;
          end else begin
            state_nxt = START;
            tx_nxt    = 1'b0;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tx_nxt    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_nxt = PARITY;
              tx_nxt    = par_q;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            tx_nxt = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        // bit_idx counts stop bits here so STOP2 stretches the state to 2P
        if (bit_end && (bit_idx == BIT_W'(stop2_q))) begin
          byte_done_nxt = 1'b1;
          if (byte_cnt > BYTE_CNT_WIDTH'(1)) begin
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt    = IDLE;
            tx_nxt       = 1'b1;
            cmd_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != IDLE) busy_nxt = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      tx_q        <= 1'b1;
      byte_done_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      tx_q        <= tx_nxt;
      byte_done_q <= byte_done_nxt;
      cmd_done_q  <= cmd_done_nxt;
      busy_q      <= busy_nxt;
      cnt         <= ((state == IDLE) || bit_end) ? '0 : cnt + PRESCALE_WIDTH'(1);
      if (state_nxt != state)
        bit_idx <= '0;
      else if (bit_end && ((state == DATA) || (state == STOP)))
        bit_idx <= bit_idx + BIT_W'(1);
      if (accept)
        byte_cnt <= clamp_len(CMD_LEN);
      else if (byte_done_nxt)
        byte_cnt <= byte_cnt - BYTE_CNT_WIDTH'(1);
    end
  end

  // Captured command and frame format; only meaningful while a command is in flight
  always_ff @(posedge CLK) begin
    if (accept) begin
      cmd_q     <= CMD_DATA;
      pm1_q     <= period_m1(BIT_PERIOD);
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      stop2_q   <= STOP2;
    end
    if (load_byte) begin
      sh_q  <= cur_byte;
      par_q <= parity_bit(cur_byte, par_typ_q);
    end else if ((state == DATA) && bit_end) begin
      sh_q <= sh_q >> 1;
    end
  end

  assign CMD_RDY   = (state == IDLE);
  assign TX_OUT    = tx_q;
  assign BUSY      = busy_q;
  assign BYTE_DONE = byte_done_q;
  assign CMD_DONE  = cmd_done_q;

endmodule

// File: tb/tb_uart_cmd_stream_tx.sv
// Directed bench for uart_cmd_stream_tx: table of commands with hand-computed line
// content and completion cycle, plus handshake and mid-frame reset sequences.
module tb_uart_cmd_stream_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] CMD_DATA;
  logic [2:0]  CMD_LEN;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic        PAR_EN, PAR_TYP, STOP2;
  logic [5:0]  BIT_PERIOD;
  logic        TX_OUT, BUSY, BYTE_DONE, CMD_DONE;

  int tests = 0;
  int fails = 0;

  uart_cmd_stream_tx #(
    .DATA_WIDTH(8), .MAX_BYTES(4), .BYTE_CNT_WIDTH(3), .PRESCALE_WIDTH(6)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_DATA(CMD_DATA), .CMD_LEN(CMD_LEN), .CMD_VLD(CMD_VLD),
    .CMD_RDY(CMD_RDY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .BIT_PERIOD(BIT_PERIOD), .TX_OUT(TX_OUT), .BUSY(BUSY), .BYTE_DONE(BYTE_DONE),
    .CMD_DONE(CMD_DONE)
  );

  always #5 CLK = ~CLK;

  // bytes: expected bytes in line order, first sent in [7:0]; par[j]: parity of frame j
  typedef struct {
    logic [31:0] data;
    logic [2:0]  len;
    logic        pe, pt, s2;
    logic [5:0]  bp;
    int          n;
    logic [31:0] bytes;
    logic [3:0]  par;
    int          done;
  } vec_t;

  vec_t vecs[7];
  vec_t hs_a, hs_b;

  task automatic check(input string what, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", what, got, want);
    end
  endtask

  function automatic int frame_len(input vec_t v);
    return 10 + int'(v.pe) + int'(v.s2);
  endfunction

  function automatic int per(input vec_t v);
    return (v.bp == 0) ? 1 : int'(v.bp);
  endfunction

  function automatic logic line_bit(input vec_t v, input int k);
    int f, p, idx, j, b;
    f = frame_len(v);
    p = per(v);
    if (k < 1 || k > v.n * f * p) return 1'b1;
    idx = k - 1;
    j = idx / (f * p);
    b = (idx % (f * p)) / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return v.bytes[8*j + b - 1];
    if (b == 9 && v.pe) return v.par[j];
    return 1'b1;
  endfunction

  task automatic drive(input vec_t v);
    CMD_DATA   = v.data;
    CMD_LEN    = v.len;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    STOP2      = v.s2;
    BIT_PERIOD = v.bp;
    CMD_VLD    = 1'b1;
  endtask

  // Called in cycle 1 after the acceptance edge; returns while sampling the CMD_DONE cycle.
  task automatic observe(input vec_t v, input string tag, input int inj_k,
                         input int hold_k, input vec_t nxt);
    int f, p, nfp, fp;
    int tx_e, bd_e, cd_e, busy_e, rdy_e;
    logic e_bd, e_busy, e_rdy;
    f = frame_len(v);
    p = per(v);
    fp = f * p;
    nfp = v.n * fp;
    tx_e = 0; bd_e = 0; cd_e = 0; busy_e = 0; rdy_e = 0;
    for (int k = 1; k <= v.done; k++) begin
      e_bd   = (k > 1) && ((k - 1) % fp == 0) && ((k - 1) / fp <= v.n);
      e_busy = (k <= nfp) || (v.n == 0 && k == 1);
      e_rdy  = (k > nfp);
      if (TX_OUT !== line_bit(v, k)) tx_e++;
      if (BYTE_DONE !== e_bd) bd_e++;
      if (CMD_DONE !== (k == v.done)) cd_e++;
      if (BUSY !== e_busy) busy_e++;
      if (CMD_RDY !== e_rdy) rdy_e++;
      if (k == inj_k) begin
        check({tag, " rdy_mid_cmd"}, int'(CMD_RDY), 0);
        CMD_DATA = 32'hFFFF_FFFF; CMD_LEN = 3'd1; PAR_EN = ~v.pe; BIT_PERIOD = 6'd1;
        CMD_VLD = 1'b1;
      end else if (k == inj_k + 1) begin
        CMD_VLD = 1'b0;
      end
      if (k == hold_k) drive(nxt);
      if (k < v.done) begin
        @(posedge CLK); #1;
      end
    end
    check({tag, " tx_errs"},   tx_e,   0);
    check({tag, " bdone_errs"}, bd_e,  0);
    check({tag, " cdone_errs"}, cd_e,  0);
    check({tag, " busy_errs"}, busy_e, 0);
    check({tag, " rdy_errs"},  rdy_e,  0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge CLK); #1;
    check({tag, " idle_after"}, int'({TX_OUT, BUSY, CMD_DONE, BYTE_DONE}), 8);
  endtask

  initial begin
    int cd_seen, tx_low;
    vecs[0] = '{32'hCC08_0203, 3'd4, 1'b1, 1'b0, 1'b0, 6'd4, 4, 32'h0302_08CC, 4'b0110, 177};
    vecs[1] = '{32'h0000_BB01, 3'd2, 1'b0, 1'b0, 1'b1, 6'd4, 2, 32'h0000_01BB, 4'b0000, 89};
    vecs[2] = '{32'h0000_0000, 3'd1, 1'b1, 1'b1, 1'b0, 6'd0, 1, 32'h0000_0000, 4'b0001, 12};
    vecs[3] = '{32'h1122_3344, 3'd7, 1'b0, 1'b0, 1'b0, 6'd2, 4, 32'h4433_2211, 4'b0000, 81};
    vecs[4] = '{32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0, 1'b0, 6'd3, 0, 32'h0000_0000, 4'b0000, 1};
    vecs[5] = '{32'hA55A_F00F, 3'd3, 1'b1, 1'b1, 1'b1, 6'd3, 3, 32'h000F_F05A, 4'b0111, 109};
    vecs[6] = '{32'h0000_0007, 3'd1, 1'b1, 1'b0, 1'b0, 6'd1, 1, 32'h0000_0007, 4'b0001, 12};
    hs_a    = '{32'h0000_A55A, 3'd2, 1'b0, 1'b0, 1'b0, 6'd2, 2, 32'h0000_5AA5, 4'b0000, 41};
    hs_b    = '{32'h0000_003C, 3'd1, 1'b1, 1'b1, 1'b1, 6'd3, 1, 32'h0000_003C, 4'b0001, 37};

    RST = 1'b1; CMD_VLD = 1'b0; CMD_DATA = '0; CMD_LEN = '0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; BIT_PERIOD = 6'd4;
    repeat (2) @(posedge CLK);
    #1;
    check("reset tx", int'(TX_OUT), 1);
    check("reset rdy", int'(CMD_RDY), 1);
    check("reset busy", int'(BUSY), 0);
    check("reset bdone", int'(BYTE_DONE), 0);
    check("reset cdone", int'(CMD_DONE), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i]);
      @(posedge CLK); #1;
      CMD_VLD = 1'b0;
      observe(vecs[i], $sformatf("vec%0d", i), -5, -1, vecs[i]);
      idle_check($sformatf("vec%0d", i));
    end

    // Ignored mid-command request, then a held request accepted in the CMD_DONE cycle
    drive(hs_a);
    @(posedge CLK); #1;
    CMD_VLD = 1'b0;
    observe(hs_a, "hs_a", 10, 25, hs_b);
    @(posedge CLK); #1;
    CMD_VLD = 1'b0;
    observe(hs_b, "hs_b", -5, -1, hs_b);
    idle_check("hs_b");

    // Asynchronous reset during the data bits of the second byte
    drive(vecs[0]);
    @(posedge CLK); #1;
    CMD_VLD = 1'b0;
    repeat (55) @(posedge CLK);
    #2;
    check("rst pre busy", int'(BUSY), 1);
    check("rst pre tx", int'(TX_OUT), 0);
    RST = 1'b1;
    #1;
    check("rst async tx", int'(TX_OUT), 1);
    check("rst async busy", int'(BUSY), 0);
    check("rst async rdy", int'(CMD_RDY), 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    cd_seen = 0;
    tx_low = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge CLK); #1;
      if (CMD_DONE) cd_seen++;
      if (!TX_OUT) tx_low++;
    end
    check("rst no cdone", cd_seen, 0);
    check("rst line idle", tx_low, 0);
    drive(vecs[5]);
    @(posedge CLK); #1;
    CMD_VLD = 1'b0;
    observe(vecs[5], "post_rst", -5, -1, vecs[5]);
    idle_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_stream_tx.md
# uart_cmd_stream_tx

Parametrised UART command-stream transmitter that serialises a multi-byte command word into back-to-back UART frames. Data width, command length, bit period, parity and stop-bit count are all configurable. It sits in front of the system's `RX_IN` pin and drives host-side command traffic (register read/write, ALU ops) into the communication system. It supersedes the fixed 4-byte, fixed-parity command streaming done in simulation with a synthesisable, run-time-configurable engine.

## Interface
- `DATA_WIDTH`, 8, bits per UART data field.
- `MAX_BYTES`, 4, maximum bytes per command.
- `BYTE_CNT_WIDTH`, 3, width of `CMD_LEN`; must hold `MAX_BYTES`.
- `PRESCALE_WIDTH`, 6, width of `BIT_PERIOD`.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  asynchronous, active-high reset.
- `CMD_DATA`  in  `MAX_BYTES*DATA_WIDTH`  command word; bytes sent are the `CMD_LEN` least-significant bytes, most-significant of those first.
- `CMD_LEN`  in  `BYTE_CNT_WIDTH`  number of bytes to send.
- `CMD_VLD`  in  1  command request.
- `CMD_RDY`  out  1  high in IDLE; a command is accepted on the edge where `CMD_VLD && CMD_RDY`.
- `PAR_EN`  in  1  parity bit present.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `STOP2`  in  1  two stop bits when 1.
- `BIT_PERIOD`  in  `PRESCALE_WIDTH`  clocks per UART bit; 0 is treated as 1.
- `TX_OUT`  out  1  serial line, registered, idle high.
- `BUSY`  out  1  high from acceptance until return to IDLE.
- `BYTE_DONE`  out  1  one-cycle pulse per completed frame.
- `CMD_DONE`  out  1  one-cycle pulse per completed command.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **Capture at acceptance.** All of `CMD_DATA`, `CMD_LEN`, `PAR_EN`, `PAR_TYP`, `STOP2` and `BIT_PERIOD` are captured at acceptance. Input changes afterwards have no effect until the next acceptance.
- **`CMD_LEN` out of range.**
  - `CMD_LEN` > `MAX_BYTES` is clamped to `MAX_BYTES`.
  - `CMD_LEN` = 0 is accepted: no frames are sent, `TX_OUT` stays 1, and `CMD_DONE` pulses in the next cycle. `BUSY` is high for that one cycle.
- **Transitions:**
  - IDLE→START on acceptance.
  - START→DATA after P cycles.
  - DATA shifts LSB first. After `DATA_WIDTH` bits it goes to PARITY if `PAR_EN`, else STOP.
  - PARITY→STOP after P cycles.
  - STOP lasts P or 2P cycles (`STOP2`), then goes to START if bytes remain, else IDLE.
- **Parity bit:** `^byte` when `PAR_TYP`=0, `~^byte` when `PAR_TYP`=1.
- **Frame length:** F = 1 + `DATA_WIDTH` + `PAR_EN` + 1 + `STOP2` bits. Consecutive frames within a command have no gap.
- **Counters:**
  - Bit-period counter counts 0..P-1.
  - Bit index counts 0..`DATA_WIDTH`-1.
  - Byte counter counts down from the clamped length.
  - No counter wraps beyond its terminal value.
- `CMD_VLD` while `CMD_RDY`=0 is ignored: no queueing, no error.
- **Reset** (asserted at any time, including mid-frame), immediately and asynchronously:
  - `TX_OUT`=1.
  - `BUSY`, `BYTE_DONE`, `CMD_DONE` = 0 and `CMD_RDY`=1.
  - State IDLE; the in-flight command is discarded.

## Timing
- **Reset values:** `TX_OUT`=1, `CMD_RDY`=1, `BUSY`=0, `BYTE_DONE`=0, `CMD_DONE`=0.
- **Start of transmission:** acceptance at edge t0 means `TX_OUT`=0 in the cycle after t0, for P cycles.
- **Bit timing:** each bit holds for exactly P cycles; `TX_OUT` changes only on bit boundaries.
- **End of command:** the last stop bit ends at edge t0 + N·F·P (N = byte count). In the following cycle:
  - the FSM is in IDLE with `CMD_DONE`=1;
  - `BUSY`=0 and `CMD_RDY`=1;
  - `TX_OUT`=1.
- **`BYTE_DONE` placement:**
  - Intermediate frames: `BYTE_DONE` pulses in the first cycle after the frame's last stop cycle, coincident with the next start bit.
  - Final frame: it coincides with `CMD_DONE`.
- **Back-to-back commands:** a command presented during the `CMD_DONE` cycle is accepted there, which leaves exactly one idle-high clock between commands.

## Test plan
- **Four-byte command, even parity.** `CMD_DATA`=0xCC080203, LEN=4, `PAR_EN`=1, `PAR_TYP`=0, `STOP2`=0, P=4.
  - Line carries 0xCC, 0x08, 0x02, 0x03 LSB first with parity 0, 1, 1, 0.
  - First frame bits: 0,0,0,1,1,0,0,1,1,0,1.
  - Three `BYTE_DONE` pulses, then `BYTE_DONE` together with `CMD_DONE` 177 cycles after the acceptance edge.
- **Two-byte command, no parity, two stop bits.** `CMD_DATA`=0x0000BB01, LEN=2, `PAR_EN`=0, `STOP2`=1, P=4.
  - 0xBB then 0x01, each frame 11 bits long.
  - `CMD_DONE` 89 cycles after acceptance.
- **Odd parity, minimum period.** LEN=1, byte 0x00, `PAR_TYP`=1, `PAR_EN`=1, `BIT_PERIOD`=0.
  - P behaves as 1 and the parity bit is 1.
  - `CMD_DONE` 12 cycles after acceptance.
- **Handshake.**
  - `CMD_VLD` pulsed mid-command is ignored: `CMD_RDY`=0 and the line is unaffected.
  - A second command held on `CMD_VLD` is accepted in the `CMD_DONE` cycle, giving exactly one idle clock between frames.
- **Reset mid-frame.** `RST` asserted during the DATA bits of byte 2 of a 4-byte command.
  - `TX_OUT`=1 and `BUSY`=0 immediately.
  - No `CMD_DONE`.
  - After release, a new command transmits correctly.
- **Length bounds.**
  - LEN=0 gives `CMD_DONE` one cycle after acceptance with `TX_OUT` constantly 1.
  - LEN=7 sends exactly 4 frames (clamped).
